// File: rtl/bo_datapath.sv
// Operative block: X / H_r / S registers, add-or-multiply ALU,
// program-end detection with pronto strobe, sticky ovf and erro.
module bo_datapath #(
  parameter int W       = 8,
  parameter int MAX_CYC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         LX,
  input  logic         LS,
  input  logic         LH,
  input  logic         H,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] coef_a,
  input  logic [W-1:0] coef_b,
  input  logic [W-1:0] coef_c,
  output logic [W-1:0] y_out,
  output logic         pronto,
  output logic         ovf,
  output logic         erro
);

  localparam int CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    x;
  logic [W-1:0]    s;
  logic [W-1:0]    h_r;
  logic [CW-1:0]   cyc;
  logic            ls_seen;

  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic [W-1:0]    s_src;
  logic [W-1:0]    r;
  logic [2*W-1:0]  prod;
  logic [W:0]      sum;
  logic            ovf_now;
  logic            idle_word;
  logic            ovf_upd;

  always_comb begin
    unique case (M0)
      2'd0:    opa = x;
      2'd1:    opa = s;
      2'd2:    opa = h_r;
      default: opa = x_in;
    endcase
    unique case (M1)
      2'd0:    opb = x;
      2'd1:    opb = coef_a;
      2'd2:    opb = coef_b;
      default: opb = coef_c;
    endcase
  end

  assign prod    = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
  assign sum     = {1'b0, opa} + {1'b0, opb};
  assign r       = H ? prod[W-1:0] : sum[W-1:0];
  assign ovf_now = H ? |prod[2*W-1:W] : sum[W];

  always_comb begin
    unique case (M2)
      2'd0:    s_src = r;
      2'd1:    s_src = h_r;
      2'd2:    s_src = coef_c;
      default: s_src = '0;
    endcase
  end

  assign idle_word = !LX && !LS && !LH && !H &&
                     (M0 == 2'd0) && (M1 == 2'd0) &&
                     (M2 == 2'd0);
  assign ovf_upd   = (LS && (M2 == 2'd0)) || LH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      x       <= '0;
      s       <= '0;
      h_r     <= '0;
      cyc     <= '0;
      ls_seen <= 1'b0;
      y_out   <= '0;
      pronto  <= 1'b0;
      ovf     <= 1'b0;
      erro    <= 1'b0;
    end else begin
      if (LX) x <= x_in;
      if (LH) h_r <= r;
      if (LS) s <= s_src;
      pronto <= 1'b0;
      unique case (state)
        RUN: begin
          if (LX) begin
            ovf     <= 1'b0;
            cyc     <= '0;
            ls_seen <= 1'b0;
          end else if (idle_word && ls_seen) begin
            y_out  <= s;
            pronto <= 1'b1;
            state  <= DONE;
          end else begin
            cyc <= cyc + 1'b1;
            if (ovf_upd) ovf <= ovf | ovf_now;
            if (LS) ls_seen <= 1'b1;
            if (cyc == CW'(MAX_CYC - 1)) begin
              erro  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          // IDLE and DONE share the start-of-program behaviour
          if (LX) begin
            state   <= RUN;
            ovf     <= 1'b0;
            erro    <= 1'b0;
            cyc     <= '0;
            ls_seen <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bo_datapath.sv
// Bench for bo_datapath: directed vector table, timeout and reset
// sequences, then random control words against a behavioural model.
module tb_bo_datapath;

  localparam int W       = 8;
  localparam int MAX_CYC = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         LX = 0, LS = 0, LH = 0, H = 0;
  logic [1:0]   M0 = 0, M1 = 0, M2 = 0;
  logic [W-1:0] x_in = 0, coef_a = 0, coef_b = 0, coef_c = 0;
  logic [W-1:0] y_out;
  logic         pronto, ovf, erro;

  bo_datapath #(.W(W), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .reset(reset),
    .LX(LX), .LS(LS), .LH(LH), .H(H),
    .M0(M0), .M1(M1), .M2(M2),
    .x_in(x_in), .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .y_out(y_out), .pronto(pronto), .ovf(ovf), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lx, ls, lh, h;
    int m0, m1, m2, xin;
    int ey, ep, eo, ee, es, eh, ex;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // behavioural model
  int mx, ms, mh, my, mcnt;
  bit mp, mo, me, mrun, mdone, mseen;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mx = 0; ms = 0; mh = 0; my = 0; mcnt = 0;
    mp = 0; mo = 0; me = 0; mrun = 0; mdone = 0; mseen = 0;
  endtask

  task automatic model_edge(input vec_t v);
    int a, b, full, r, src;
    bit on, idle;
    a = (v.m0 == 0) ? mx : (v.m0 == 1) ? ms : (v.m0 == 2) ? mh : v.xin;
    b = (v.m1 == 0) ? mx : (v.m1 == 1) ? int'(coef_a) :
        (v.m1 == 2) ? int'(coef_b) : int'(coef_c);
    full = v.h ? a * b : a + b;
    r    = full % 256;
    on   = full > 255;
    src  = (v.m2 == 0) ? r : (v.m2 == 1) ? mh : (v.m2 == 2) ? int'(coef_c) : 0;
    idle = !v.lx && !v.ls && !v.lh && !v.h &&
           v.m0 == 0 && v.m1 == 0 && v.m2 == 0;
    mp = 0;
    if (!mrun) begin
      mdone = 0;
      if (v.lx) begin
        mrun = 1; mo = 0; me = 0; mcnt = 0; mseen = 0;
      end
    end else if (v.lx) begin
      mo = 0; mcnt = 0; mseen = 0;
    end else if (idle && mseen) begin
      my = ms; mp = 1; mrun = 0; mdone = 1;
    end else begin
      if ((v.ls && v.m2 == 0) || v.lh) mo = mo | on;
      if (v.ls) mseen = 1;
      if (mcnt == MAX_CYC - 1) begin
        me = 1; mrun = 0;
      end
      mcnt++;
    end
    if (v.lx) mx = v.xin;
    if (v.lh) mh = r;
    if (v.ls) ms = src;
  endtask

  task automatic step(input vec_t v);
    LX = v.lx; LS = v.ls; LH = v.lh; H = v.h;
    M0 = v.m0[1:0]; M1 = v.m1[1:0]; M2 = v.m2[1:0];
    x_in = v.xin[W-1:0];
    @(posedge clk);
    model_edge(v);
    #1;
    chk("y_out", int'(y_out), my);
    chk("pronto", int'(pronto), int'(mp));
    chk("ovf", int'(ovf), int'(mo));
    chk("erro", int'(erro), int'(me));
    chk("S", int'(dut.s), ms);
    chk("H_r", int'(dut.h_r), mh);
    chk("X", int'(dut.x), mx);
  endtask

  task automatic chk_row(input int i);
    chk($sformatf("row%0d y_out", i), int'(y_out), tbl[i].ey);
    chk($sformatf("row%0d pronto", i), int'(pronto), tbl[i].ep);
    chk($sformatf("row%0d ovf", i), int'(ovf), tbl[i].eo);
    chk($sformatf("row%0d erro", i), int'(erro), tbl[i].ee);
    chk($sformatf("row%0d S", i), int'(dut.s), tbl[i].es);
    chk($sformatf("row%0d H_r", i), int'(dut.h_r), tbl[i].eh);
    chk($sformatf("row%0d X", i), int'(dut.x), tbl[i].ex);
  endtask

  function automatic vec_t mk(bit lx, bit ls, bit lh, bit h,
                              int m0, int m1, int m2, int xin);
    vec_t v;
    v = '{lx:lx, ls:ls, lh:lh, h:h, m0:m0, m1:m1, m2:m2, xin:xin,
          ey:0, ep:0, eo:0, ee:0, es:0, eh:0, ex:0};
    return v;
  endfunction

  initial begin
    vec_t v;
    int   r;
    // lx ls lh h m0 m1 m2 xin | y p o e s h x
    tbl.push_back('{1,0,0,0, 0,0,0,3,     0,0,0,0,  0,  0,  3});
    tbl.push_back('{0,0,1,1, 0,1,0,0,     0,0,0,0,  0,  6,  3});
    tbl.push_back('{0,1,0,0, 2,2,0,0,     0,0,0,0, 11,  6,  3});
    tbl.push_back('{0,0,0,0, 0,0,0,0,    11,1,0,0, 11,  6,  3});
    tbl.push_back('{0,0,0,0, 0,0,0,0,    11,0,0,0, 11,  6,  3});
    tbl.push_back('{1,0,0,0, 0,0,0,200,  11,0,0,0, 11,  6,200});
    tbl.push_back('{0,0,1,1, 0,1,0,0,    11,0,1,0, 11,144,200});
    tbl.push_back('{0,1,0,0, 0,0,1,0,    11,0,1,0,144,144,200});
    tbl.push_back('{0,0,0,0, 0,0,0,0,   144,1,1,0,144,144,200});
    tbl.push_back('{0,0,0,0, 0,0,0,0,   144,0,1,0,144,144,200});
    tbl.push_back('{1,0,0,0, 0,0,0,4,   144,0,0,0,144,144,  4});
    tbl.push_back('{0,1,1,0, 0,0,0,0,   144,0,0,0,  8,  8,  4});
    tbl.push_back('{0,1,1,0, 3,1,1,1,   144,0,0,0,  8,  3,  4});
    tbl.push_back('{0,0,0,0, 0,0,0,0,     8,1,0,0,  8,  3,  4});
    tbl.push_back('{0,0,0,0, 0,0,0,0,     8,0,0,0,  8,  3,  4});
    tbl.push_back('{1,0,0,0, 0,0,0,7,     8,0,0,0,  8,  3,  7});
    tbl.push_back('{0,0,0,0, 0,0,0,0,     8,0,0,0,  8,  3,  7});
    tbl.push_back('{0,0,0,0, 0,0,0,0,     8,0,0,0,  8,  3,  7});
    tbl.push_back('{0,0,1,1, 3,1,0,200,   8,0,1,0,  8,144,  7});
    tbl.push_back('{1,0,0,0, 0,0,0,9,     8,0,0,0,  8,144,  9});
    tbl.push_back('{0,1,0,0, 0,0,2,0,     8,0,0,0,  1,144,  9});
    tbl.push_back('{0,0,0,0, 0,0,0,0,     1,1,0,0,  1,144,  9});
    tbl.push_back('{0,0,0,0, 0,0,0,0,     1,0,0,0,  1,144,  9});

    coef_a = 8'd2; coef_b = 8'd5; coef_c = 8'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset y_out", int'(y_out), 0);
    chk("reset pronto", int'(pronto), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset erro", int'(erro), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
      chk_row(i);
    end

    // timeout: never send the idle word
    step(mk(1, 0, 0, 0, 0, 0, 0, 1));
    for (int i = 1; i <= MAX_CYC; i++) begin
      step(mk(0, 0, 1, 0, 3, 0, 0, 1));
      chk($sformatf("tmo erro edge%0d", i), int'(erro), (i == MAX_CYC) ? 1 : 0);
      chk("tmo pronto", int'(pronto), 0);
      chk("tmo y_out", int'(y_out), 1);
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("tmo idle erro", int'(erro), 1);
    chk("tmo idle pronto", int'(pronto), 0);

    // asynchronous reset between edges, mid-RUN
    step(mk(1, 0, 0, 0, 0, 0, 0, 5));
    step(mk(0, 0, 1, 1, 3, 1, 0, 200));
    chk("pre-reset ovf", int'(ovf), 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async y_out", int'(y_out), 0);
    chk("async pronto", int'(pronto), 0);
    chk("async ovf", int'(ovf), 0);
    chk("async erro", int'(erro), 0);
    chk("async S", int'(dut.s), 0);
    chk("async H_r", int'(dut.h_r), 0);
    chk("async X", int'(dut.x), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(tbl[i]);
      chk_row(i);
    end

    // random control words against the model
    coef_a = W'($urandom); coef_b = W'($urandom); coef_c = W'($urandom);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      v = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      if (r == 0) v.lx = 1;
      else v.lx = 0;
      if (r >= 1 && r <= 4) begin
        v.ls = 0; v.lh = 0; v.h = 0; v.m0 = 0; v.m1 = 0; v.m2 = 0;
      end
      step(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
